rob_commit: RTL and testbench

- Retire stage sitting on the pop side of the ROB.
- Watches the ROB head (instr, value, ready, empty) and decides when to pop it.
- Drives the architectural register-file write port, and runs a request/ack handshake with the store buffer for stores.
- Enters a terminal halted state on a halt instruction or a store timeout. Sits between the ROB and the regfile/store buffer.

---
 rtl/rob_commit.sv | 124 ++++++++++++
 tb/tb_rob_commit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Retire stage on the ROB pop side: writes the regfile, releases stores, halts.
// Optional retired_count output is enabled by defining RETIRE_COUNT_EN.
module rob_commit #(
  parameter logic [4:0]  OPCODE_STORE = 5'b00111,
  parameter logic [4:0]  OPCODE_HALT  = 5'b11111,
  parameter int unsigned ST_TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rob_empty,
  input  logic        rob_head_ready,
  input  logic [31:0] rob_head_instr,
  input  logic [31:0] rob_head_val,
  input  logic        commit_stall,
  output logic        rob_pop,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        st_commit,
  output logic [31:0] st_tag,
  input  logic        st_ack,
  output logic        halted,
`ifdef RETIRE_COUNT_EN
  output logic [31:0] retired_count,
`endif
  output logic        st_error
);

  localparam int unsigned CntW = $clog2(ST_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ST_TIMEOUT - 1);

  typedef enum logic [1:0] {StRun, StStoreWait, StHalted} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;

  logic [4:0] op;
  logic [4:0] rd;
  logic       go;
  logic       is_store;
  logic       is_halt;
  logic       unused_instr_bits;

  assign op                = rob_head_instr[31:27];
  assign rd                = rob_head_instr[26:22];
  assign go                = !rob_empty && rob_head_ready && !commit_stall;
  assign is_store          = (op == OPCODE_STORE);
  assign is_halt           = (op == OPCODE_HALT);
  assign unused_instr_bits = ^rob_head_instr[21:0];

  // Pop is gated by reset so an interrupted store is never retired.
  always_comb begin
    rob_pop = 1'b0;
    if (reset) begin
      case (state_q)
        StRun:       rob_pop = go && !is_store;
        StStoreWait: rob_pop = st_ack && !rob_empty;
        default:     rob_pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      st_commit <= 1'b0;
      st_tag    <= '0;
      halted    <= 1'b0;
      st_error  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state_q)
        StRun: begin
          if (go) begin
            if (is_store) begin
              st_commit <= 1'b1;
              st_tag    <= rob_head_val;
              cnt_q     <= '0;
              state_q   <= StStoreWait;
            end else if (is_halt) begin
              halted  <= 1'b1;
              state_q <= StHalted;
            end else if (rd != 5'd0) begin
              rf_we    <= 1'b1;
              rf_waddr <= rd;
              rf_wdata <= rob_head_val;
            end
          end
        end
        StStoreWait: begin
          if (st_ack) begin
            st_commit <= 1'b0;
            state_q   <= StRun;
          end else if (cnt_q == CntLast) begin
            // Ack window exhausted: the wait lasts exactly ST_TIMEOUT cycles.
            st_commit <= 1'b0;
            st_error  <= 1'b1;
            halted    <= 1'b1;
            state_q   <= StHalted;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHalted: ;
        default: state_q <= StHalted;
      endcase
    end
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (rob_pop) begin
      retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Directed self-checking bench for rob_commit; covers RETIRE_COUNT_EN when defined.
module tb_rob_commit;

  logic        clock = 1'b0;
  logic        reset;
  logic        rob_empty;
  logic        rob_head_ready;
  logic [31:0] rob_head_instr;
  logic [31:0] rob_head_val;
  logic        commit_stall;
  logic        rob_pop;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        st_commit;
  logic [31:0] st_tag;
  logic        st_ack;
  logic        halted;
  logic        st_error;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rob_commit #(
    .OPCODE_STORE(5'b00111),
    .OPCODE_HALT (5'b11111),
    .ST_TIMEOUT  (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rob_empty     (rob_empty),
    .rob_head_ready(rob_head_ready),
    .rob_head_instr(rob_head_instr),
    .rob_head_val  (rob_head_val),
    .commit_stall  (commit_stall),
    .rob_pop       (rob_pop),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .st_commit     (st_commit),
    .st_tag        (st_tag),
    .st_ack        (st_ack),
    .halted        (halted),
`ifdef RETIRE_COUNT_EN
    .retired_count (retired_count),
`endif
    .st_error      (st_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
    return {op, rd, 22'd0};
  endfunction

  task automatic set_head(input logic [31:0] instr, input logic [31:0] val);
    rob_head_instr = instr;
    rob_head_val   = val;
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    rob_empty      = 1'b0;
    rob_head_ready = 1'b1;
    rob_head_instr = mk(5'b00000, 5'd5);
    rob_head_val   = 32'd42;
    commit_stall   = 1'b0;
    st_ack         = 1'b0;

    // 1: reset with a ready head
    step();
    step();
    check("rst_pop", {31'd0, rob_pop}, 32'd0);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_stc", {31'd0, st_commit}, 32'd0);
    check("rst_tag", st_tag, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, st_error}, 32'd0);
    reset = 1'b1;
    #1;
    check("first_pop", {31'd0, rob_pop}, 32'd1);

    // 2: first write, then three back-to-back commits
    step();
    check("w5_we", {31'd0, rf_we}, 32'd1);
    check("w5_addr", {27'd0, rf_waddr}, 32'd5);
    check("w5_data", rf_wdata, 32'd42);
    for (int i = 1; i <= 3; i++) begin
      set_head(mk(5'b00000, 5'(i)), 32'(i * 10));
      check("b2b_pop", {31'd0, rob_pop}, 32'd1);
      step();
      check("b2b_we", {31'd0, rf_we}, 32'd1);
      check("b2b_addr", {27'd0, rf_waddr}, 32'(i));
      check("b2b_data", rf_wdata, 32'(i * 10));
    end

    // 3: rd==0, stall, empty
    set_head(mk(5'b00000, 5'd0), 32'd99);
    check("rd0_pop", {31'd0, rob_pop}, 32'd1);
    step();
    check("rd0_we", {31'd0, rf_we}, 32'd0);
    commit_stall = 1'b1;
    #1;
    check("stall_pop", {31'd0, rob_pop}, 32'd0);
    step();
    check("stall_we", {31'd0, rf_we}, 32'd0);
    commit_stall = 1'b0;
    rob_empty    = 1'b1;
    #1;
    check("empty_pop", {31'd0, rob_pop}, 32'd0);
    step();
    check("empty_we", {31'd0, rf_we}, 32'd0);
    rob_empty = 1'b0;

    // 4: store acked on the 3rd wait cycle
    set_head(mk(5'b00111, 5'd3), 32'h1234);
    check("st_nopop", {31'd0, rob_pop}, 32'd0);
    step();
    check("st_commit1", {31'd0, st_commit}, 32'd1);
    check("st_tag1", st_tag, 32'h1234);
    check("st_we", {31'd0, rf_we}, 32'd0);
    commit_stall = 1'b1;
    rob_head_val = 32'hdead;
    #1;
    check("sw1_pop", {31'd0, rob_pop}, 32'd0);
    step();
    check("st_commit2", {31'd0, st_commit}, 32'd1);
    check("st_tag2", st_tag, 32'h1234);
    step();
    st_ack = 1'b1;
    #1;
    check("ack_pop", {31'd0, rob_pop}, 32'd1);
    step();
    st_ack       = 1'b0;
    commit_stall = 1'b0;
    set_head(mk(5'b00000, 5'd7), 32'd77);
    check("ack_stc", {31'd0, st_commit}, 32'd0);
    check("run_pop", {31'd0, rob_pop}, 32'd1);
    step();
    check("run_we", {31'd0, rf_we}, 32'd1);
    check("run_addr", {27'd0, rf_waddr}, 32'd7);

    // 6: two normals then halt, from a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_head(mk(5'b00000, 5'd1), 32'd1);
    check("h_pop1", {31'd0, rob_pop}, 32'd1);
    step();
    set_head(mk(5'b00000, 5'd2), 32'd2);
    check("h_pop2", {31'd0, rob_pop}, 32'd1);
    step();
    set_head(mk(5'b11111, 5'd4), 32'd4);
    check("h_pop3", {31'd0, rob_pop}, 32'd1);
    step();
    check("h_halted", {31'd0, halted}, 32'd1);
    check("h_we", {31'd0, rf_we}, 32'd0);
    set_head(mk(5'b00000, 5'd9), 32'd9);
    for (int i = 0; i < 3; i++) begin
      check("h_nopop", {31'd0, rob_pop}, 32'd0);
      step();
      check("h_nowe", {31'd0, rf_we}, 32'd0);
    end
    check("h_err", {31'd0, st_error}, 32'd0);
`ifdef RETIRE_COUNT_EN
    check("h_count", retired_count, 32'd3);
`endif

    // 5: store timeout
    reset = 1'b0;
    step();
    reset = 1'b1;
    set_head(mk(5'b00111, 5'd0), 32'h55);
    step();
    for (int i = 0; i < 16; i++) begin
      check("to_stc", {31'd0, st_commit}, 32'd1);
      check("to_err", {31'd0, st_error}, 32'd0);
      check("to_pop", {31'd0, rob_pop}, 32'd0);
      step();
    end
    check("to_err_set", {31'd0, st_error}, 32'd1);
    check("to_halted", {31'd0, halted}, 32'd1);
    check("to_stc_off", {31'd0, st_commit}, 32'd0);
    set_head(mk(5'b00000, 5'd6), 32'd6);
    st_ack = 1'b1;
    #1;
    check("to_nopop", {31'd0, rob_pop}, 32'd0);
    step();
    check("to_nowe", {31'd0, rf_we}, 32'd0);
    check("to_err_hold", {31'd0, st_error}, 32'd1);
`ifdef RETIRE_COUNT_EN
    check("to_count", retired_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
